adrv9001_rx_burst_sched: RTL and testbench

//  Sequences ADRV9001 receive bursts on the rx channel's enable input: asserts rx_enable,

---
 rtl/adrv9001_rx_burst_sched.sv | 190 +++++++++++++++++++
 tb/tb_adrv9001_rx_burst_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adrv9001_rx_burst_sched.sv
// Receive-burst sequencer for an ADRV9001 rx channel: gates rx_enable per burst, counts samples,
// waits out the enable tail, then idles between bursts. Optional timestamping via ADRV9001_RX_SCHED_TS_EN.
module adrv9001_rx_burst_sched #(
    parameter int CNT_WIDTH    = 32,
    parameter int TAIL_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_WIDTH-1:0] burst_len,
    input  logic [CNT_WIDTH-1:0] burst_gap,
    input  logic [15:0]          burst_count,
    input  logic                 rx_valid,
    output logic                 rx_enable,
    output logic                 busy,
    output logic                 burst_active,
    output logic [15:0]          burst_idx,
    output logic [CNT_WIDTH-1:0] sample_cnt,
    output logic                 done,
    output logic [63:0]          burst_ts
);

    localparam int                  IDLE_W     = $clog2(TAIL_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0]   IDLE_LIMIT = IDLE_W'(TAIL_TIMEOUT);
    localparam logic [IDLE_W-1:0]   IDLE_ONE   = IDLE_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_DRAIN,
        ST_GAP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] gap_q;
    logic [CNT_WIDTH-1:0] gap_cnt;
    logic [15:0]          count_q;
    logic [IDLE_W-1:0]    idle_cnt;
    logic                 stop_seen;

    logic        sample_hit;
    logic        len_reached;
    logic        tail_done;
    logic        gap_done;
    logic        last_burst;
    logic        seq_start;
    logic        enter_on;
    logic [15:0] idx_inc;

    // Event decode plus next-state selection; every registered output is derived from state_nxt
    always_comb begin
        state_nxt   = state;
        sample_hit  = (state == ST_ON) && rx_valid;
        len_reached = sample_hit && ((sample_cnt + CNT_ONE) == len_q);
        tail_done   = (state == ST_DRAIN) && !rx_valid && ((idle_cnt + IDLE_ONE) == IDLE_LIMIT);
        gap_done    = (gap_cnt + CNT_ONE) == gap_q;
        idx_inc     = (burst_idx == 16'hFFFF) ? burst_idx : burst_idx + 16'd1;
        last_burst  = stop_seen || stop ||
                      ((count_q != 16'd0) && (({1'b0, burst_idx} + 17'd1) == {1'b0, count_q}));

        unique case (state)
            ST_IDLE: begin
                if (start && !stop && (burst_len != '0))
                    state_nxt = ST_ON;
            end
            ST_ON: begin
                if (len_reached || stop)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (tail_done) begin
                    if (last_burst)
                        state_nxt = ST_IDLE;
                    else if (gap_q == '0)
                        state_nxt = ST_ON;
                    else
                        state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (stop)
                    state_nxt = ST_IDLE;
                else if (gap_done)
                    state_nxt = ST_ON;
            end
            default: state_nxt = ST_IDLE;
        endcase

        seq_start = (state == ST_IDLE) && (state_nxt == ST_ON);
        enter_on  = (state != ST_ON) && (state_nxt == ST_ON);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Status outputs are registered copies of the upcoming state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_enable    <= 1'b0;
            burst_active <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            rx_enable    <= (state_nxt == ST_ON);
            burst_active <= (state_nxt == ST_ON);
            busy         <= (state_nxt != ST_IDLE);
            done         <= (state != ST_IDLE) && (state_nxt == ST_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q     <= '0;
            gap_q     <= '0;
            count_q   <= '0;
            burst_idx <= '0;
        end else if (seq_start) begin
            len_q     <= burst_len;
            gap_q     <= burst_gap;
            count_q   <= burst_count;
            burst_idx <= '0;
        end else if (tail_done) begin
            burst_idx <= idx_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sample_cnt <= '0;
        else if (enter_on)
            sample_cnt <= '0;
        else if (sample_hit)
            sample_cnt <= sample_cnt + CNT_ONE;
    end

    // Tail detector: any sample arriving after enable drops restarts the quiet-period count
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_cnt <= '0;
        else if ((state != ST_DRAIN) || rx_valid)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + IDLE_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            gap_cnt <= '0;
        else if (state != ST_GAP)
            gap_cnt <= '0;
        else
            gap_cnt <= gap_cnt + CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stop_seen <= 1'b0;
        else if (state_nxt == ST_IDLE)
            stop_seen <= 1'b0;
        else if (stop)
            stop_seen <= 1'b1;
    end

`ifdef ADRV9001_RX_SCHED_TS_EN
    logic [63:0] ts_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt   <= 64'h0;
            burst_ts <= 64'h0;
        end else begin
            ts_cnt <= ts_cnt + 64'd1;
            if (enter_on)
                burst_ts <= ts_cnt;
        end
    end
`else
    assign burst_ts = 64'h0;
`endif

endmodule

// File: tb/tb_adrv9001_rx_burst_sched.sv
// Directed self-checking bench for adrv9001_rx_burst_sched (default build, timestamp disabled).
module tb_adrv9001_rx_burst_sched;

    localparam int CNT_WIDTH    = 32;
    localparam int TAIL_TIMEOUT = 64;

    logic                 clk         = 1'b0;
    logic                 rst         = 1'b1;
    logic                 start       = 1'b0;
    logic                 stop        = 1'b0;
    logic                 rx_valid    = 1'b0;
    logic [CNT_WIDTH-1:0] burst_len   = '0;
    logic [CNT_WIDTH-1:0] burst_gap   = '0;
    logic [15:0]          burst_count = '0;
    logic                 rx_enable;
    logic                 busy;
    logic                 burst_active;
    logic [15:0]          burst_idx;
    logic [CNT_WIDTH-1:0] sample_cnt;
    logic                 done;
    logic [63:0]          burst_ts;

    int compared   = 0;
    int mismatched = 0;
    int overlap    = 0;

    always #5 clk = ~clk;

    adrv9001_rx_burst_sched #(
        .CNT_WIDTH    (CNT_WIDTH),
        .TAIL_TIMEOUT (TAIL_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .burst_len    (burst_len),
        .burst_gap    (burst_gap),
        .burst_count  (burst_count),
        .rx_valid     (rx_valid),
        .rx_enable    (rx_enable),
        .busy         (busy),
        .burst_active (burst_active),
        .burst_idx    (burst_idx),
        .sample_cnt   (sample_cnt),
        .done         (done),
        .burst_ts     (burst_ts)
    );

    always @(negedge clk) begin
        if (done && busy)
            overlap++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic v);
        start    = s;
        stop     = p;
        rx_valid = v;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        int   cyc;
        int   en;
        int   win;
        int   drain;
        int   drops;
        logic prev;
        logic t;
        logic got;

        // Reset state
        repeat (3) tick();
        checkOutput("rst_rx_enable", rx_enable, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_burst_active", burst_active, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_burst_idx", burst_idx, 0);
        checkOutput("rst_sample_cnt", sample_cnt, 0);
        checkOutput("rst_burst_ts", burst_ts, 0);
        rst = 1'b0;
        tick();

        // Zero-length start is ignored; start+stop together stays idle
        burst_len = 0; burst_gap = 3; burst_count = 1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("len0_busy", busy, 0);
        checkOutput("len0_rx_enable", rx_enable, 0);
        burst_len = 5;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("start_stop_busy", busy, 0);
        tick();
        checkOutput("start_stop_done", done, 0);

        // Three bursts of 100, gap 10; channel returns a sample every enabled clock
        burst_len = 100; burst_gap = 10; burst_count = 3;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_burst_active", burst_active, 1);
        burst_len = 7;
        cyc = 0; en = 0; win = 0; prev = 1'b0; got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (rx_enable) en++;
            if (rx_enable && !prev) win++;
            prev = rx_enable;
            if (done) begin got = 1'b1; break; end
            rx_valid = rx_enable;
            tick();
            cyc++;
        end
        checkOutput("t1_done_seen", got, 1);
        checkOutput("t1_cycles", cyc, 512);
        checkOutput("t1_enabled_clks", en, 300);
        checkOutput("t1_windows", win, 3);
        checkOutput("t1_burst_idx", burst_idx, 3);
        checkOutput("t1_sample_cnt", sample_cnt, 100);
        checkOutput("t1_busy_end", busy, 0);
        checkOutput("t1_burst_ts", burst_ts, 0);
        rx_valid = 1'b0;
        tick();
        checkOutput("t1_done_pulse", done, 0);

        // len=8 with valid on alternate clocks
        burst_len = 8; burst_gap = 0; burst_count = 1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        en = 0; t = 1'b1; got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!rx_enable) begin got = 1'b1; break; end
            en++;
            rx_valid = t;
            t = ~t;
            tick();
        end
        rx_valid = 1'b0;
        checkOutput("t2_enable_dropped", got, 1);
        checkOutput("t2_enabled_clks", en, 15);
        checkOutput("t2_sample_cnt", sample_cnt, 8);
        checkOutput("t2_busy_drain", busy, 1);
        cyc = 0; got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin got = 1'b1; break; end
            tick();
            cyc++;
        end
        checkOutput("t2_done_seen", got, 1);
        checkOutput("t2_tail_clks", cyc, 64);
        checkOutput("t2_burst_idx", burst_idx, 1);

        // Infinite mode, stop inside the gap after the 4th burst
        burst_len = 4; burst_gap = 10; burst_count = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (burst_idx == 16'd4) begin got = 1'b1; break; end
            rx_valid = rx_enable;
            tick();
        end
        rx_valid = 1'b0;
        checkOutput("t3_reached_idx4", got, 1);
        checkOutput("t3_gap_busy", busy, 1);
        repeat (3) tick();
        checkOutput("t3_gap_rx_enable", rx_enable, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t3_done", done, 1);
        checkOutput("t3_busy", busy, 0);
        checkOutput("t3_burst_idx", burst_idx, 4);
        tick();
        checkOutput("t3_rx_enable_after", rx_enable, 0);
        checkOutput("t3_done_pulse", done, 0);

        // Stop at sample 40 of 100; a start while busy must not restart the burst
        burst_len = 100; burst_gap = 5; burst_count = 2;
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (39) applyStimulus(1'b0, 1'b0, 1'b1);
        burst_len = 3;
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("t4_sample40", sample_cnt, 40);
        checkOutput("t4_rx_enable_pre", rx_enable, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t4_rx_enable_stop", rx_enable, 0);
        checkOutput("t4_sample_cnt", sample_cnt, 40);
        cyc = 0; got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin got = 1'b1; break; end
            tick();
            cyc++;
        end
        checkOutput("t4_done_seen", got, 1);
        checkOutput("t4_tail_clks", cyc, 64);
        checkOutput("t4_burst_idx", burst_idx, 1);

        // Samples keep arriving 20 clocks past the enable drop
        burst_len = 10; burst_gap = 0; burst_count = 1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        drain = 0; drops = 0; got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (done) begin got = 1'b1; break; end
            if (busy && !rx_enable) drain++;
            if (rx_enable)
                rx_valid = 1'b1;
            else begin
                rx_valid = (drops < 20);
                drops++;
            end
            tick();
        end
        rx_valid = 1'b0;
        checkOutput("t5_done_seen", got, 1);
        checkOutput("t5_drain_clks", drain, 84);
        checkOutput("t5_sample_cnt", sample_cnt, 10);

        // Asynchronous reset in the middle of a burst
        burst_len = 100; burst_gap = 0; burst_count = 1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t6_rx_enable_pre", rx_enable, 1);
        checkOutput("t6_sample_pre", sample_cnt, 10);
        rst = 1'b1;
        #1;
        checkOutput("t6_rx_enable_rst", rx_enable, 0);
        checkOutput("t6_busy_rst", busy, 0);
        checkOutput("t6_sample_rst", sample_cnt, 0);
        rx_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checkOutput("t6_busy_after", busy, 0);

        checkOutput("done_busy_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
